imem_loader: RTL

//  Writer side of the instruction memory: receives a framed byte stream (valid/ready) and packs it

---
 rtl/imem_loader_pkg.sv | 19 +
 rtl/imem_loader_word_packer.sv | 34 +++
 rtl/imem_loader.sv | 92 +++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared frame constants and loader state encoding
//   LD_HDR      frame start byte
//   LD_ADDR_W   default imem word-address width
//   LD_DEPTH    default imem capacity in words
//   state_t     loader FSM states
package imem_loader_pkg;
    localparam logic [7:0] LD_HDR    = 8'hA5;
    localparam int         LD_ADDR_W = 6;
    localparam int         LD_DEPTH  = 64;
    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_WRITE,
        S_CHK,
        S_DONE,
        S_ERR
    } state_t;
endpackage

// File: rtl/imem_loader_word_packer.sv
// word_packer: packs four stream bytes little-endian into one 32-bit word
//   clk, rst_n  clock, async active-low reset
//   clr         drop any partial word and restart at byte 0
//   shift       take in_byte as the next byte of the word
//   in_byte     stream byte
//   word        packed word; complete and stable after the 4th shift
//   last        the next shift completes the word
module word_packer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        shift,
    input  logic [7:0]  in_byte,
    output logic [31:0] word,
    output logic        last
);
    logic [1:0] cnt;

    assign last = cnt == 2'd3;

    // Bytes enter at the top and move down, so the first byte ends up in [7:0].
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word <= '0;
            cnt  <= '0;
        end else if (clr) begin
            word <= '0;
            cnt  <= '0;
        end else if (shift) begin
            word <= {in_byte, word[31:8]};
            cnt  <= cnt + 2'd1;
        end
    end
endmodule

// File: rtl/imem_loader.sv
// imem_loader: loads a framed, checksummed byte stream into imem and holds the core until done
//   clk, rst_n    clock, async active-low reset
//   in_valid/in_data/in_ready  byte stream handshake
//   imem_we/imem_addr/imem_wdata  imem write port (registered)
//   cpu_hold      1 keeps the core at PC=0
//   done, error   frame accepted / rejected (levels)
//   words_loaded  words written in the current or last frame
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int         ADDR_W = LD_ADDR_W,
    parameter int         DEPTH  = LD_DEPTH,
    parameter logic [7:0] HDR    = LD_HDR
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);
    state_t            state, state_nx;
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        xor_q;
    logic              accept, len_bad, word_end, pk_last;

    // in_ready depends only on state and reset, never on in_valid.
    assign in_ready     = rst_n && state != S_WRITE;
    assign accept       = in_valid && in_ready;
    assign len_bad      = in_data == 8'd0 || int'(in_data) > DEPTH;
    assign word_end     = words_loaded + 1'b1 == len_q;
    assign imem_we      = state == S_WRITE;
    assign imem_addr    = addr_q;
    assign cpu_hold     = state != S_DONE;
    assign done         = state == S_DONE;
    assign error        = state == S_ERR;

    // The packer register doubles as the write-data register: it cannot move
    // during WRITE because in_ready is low there.
    word_packer u_packer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (state == S_LEN && accept),
        .shift  (state == S_DATA && accept),
        .in_byte(in_data),
        .word   (imem_wdata),
        .last   (pk_last)
    );

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE, S_DONE, S_ERR: if (accept && in_data == HDR) state_nx = S_LEN;
            S_LEN:   if (accept) state_nx = len_bad ? S_ERR : S_DATA;
            S_DATA:  if (accept && pk_last) state_nx = S_WRITE;
            S_WRITE: state_nx = word_end ? S_CHK : S_DATA;
            S_CHK:   if (accept) state_nx = in_data == xor_q ? S_DONE : S_ERR;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            len_q        <= '0;
            addr_q       <= '0;
            words_loaded <= '0;
            xor_q        <= '0;
        end else begin
            state <= state_nx;
            if (state == S_LEN && accept && !len_bad) begin
                len_q        <= in_data[ADDR_W:0];
                addr_q       <= '0;
                words_loaded <= '0;
                xor_q        <= '0;
            end
            if (state == S_DATA && accept) xor_q <= xor_q ^ in_data;
            // A full-depth frame wraps addr to 0; words_loaded has a spare bit for DEPTH.
            if (state == S_WRITE) begin
                addr_q       <= addr_q + 1'b1;
                words_loaded <= words_loaded + 1'b1;
            end
        end
    end
endmodule
